// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: registers decoder control and decode-stage operands for EX,
// turns load-use hazards into a one-cycle bubble and counts the bubbles it inserts.
module id_ex_stage_reg #(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   flush,
  input  logic                   hold,

  input  logic                   idValid,
  input  logic [XLEN-1:0]        idPc,
  input  logic [4:0]             idRs1,
  input  logic [4:0]             idRs2,
  input  logic [4:0]             idRd,
  input  logic                   idUsesRs1,
  input  logic                   idUsesRs2,
  input  logic [XLEN-1:0]        idRs1Data,
  input  logic [XLEN-1:0]        idRs2Data,
  input  logic [XLEN-1:0]        idImm,
  input  logic [2:0]             idFunct3,
  input  logic                   idFunct7b5,
  input  logic                   idBranch,
  input  logic                   idMemRead,
  input  logic                   idMemToReg,
  input  logic                   idMemWrite,
  input  logic                   idAluSrc,
  input  logic                   idRegWrite,
  input  logic [1:0]             idAluOp,

  output logic                   exValid,
  output logic [XLEN-1:0]        exPc,
  output logic [XLEN-1:0]        exRs1Data,
  output logic [XLEN-1:0]        exRs2Data,
  output logic [XLEN-1:0]        exImm,
  output logic [4:0]             exRs1,
  output logic [4:0]             exRs2,
  output logic [4:0]             exRd,
  output logic [2:0]             exFunct3,
  output logic                   exFunct7b5,
  output logic                   exBranch,
  output logic                   exMemRead,
  output logic                   exMemToReg,
  output logic                   exMemWrite,
  output logic                   exAluSrc,
  output logic                   exRegWrite,
  output logic [1:0]             exAluOp,

  output logic                   loadUseStall,
  output logic [COUNT_WIDTH-1:0] bubbleCount
);

  // Stall handshake: loadUseStall is a combinational request valid in the same cycle
  // the hazard is visible; upstream must freeze PC and IF/ID while it is high. It is
  // not gated by hold, and flush suppresses it because the consumer is being killed.

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  ctrl_t                  id_ctrl;

  logic                   valid_q,     valid_d;
  ctrl_t                  ctrl_q,      ctrl_d;
  logic [XLEN-1:0]        pc_q,        pc_d;
  logic [XLEN-1:0]        rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]        rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]        imm_q,       imm_d;
  logic [4:0]             rs1_q,       rs1_d;
  logic [4:0]             rs2_q,       rs2_d;
  logic [4:0]             rd_q,        rd_d;
  logic [2:0]             funct3_q,    funct3_d;
  logic                   funct7b5_q,  funct7b5_d;
  logic [COUNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

  logic                   rs1_match;
  logic                   rs2_match;
  logic                   ex_is_load;
  logic                   hazard;

  assign id_ctrl = '{
    branch:     idBranch,
    mem_read:   idMemRead,
    mem_to_reg: idMemToReg,
    mem_write:  idMemWrite,
    alu_src:    idAluSrc,
    reg_write:  idRegWrite,
    alu_op:     idAluOp
  };

  // A load writing x0 never produces a value anyone waits for.
  assign ex_is_load = valid_q & ctrl_q.mem_read & (rd_q != 5'd0);
  assign rs1_match  = idUsesRs1 & (idRs1 == rd_q);
  assign rs2_match  = idUsesRs2 & (idRs2 == rd_q);
  assign hazard     = ex_is_load & idValid & (rs1_match | rs2_match);

  assign loadUseStall = hazard & ~flush;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    funct7b5_d   = funct7b5_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!hold) begin
      if (flush) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (hazard) begin
        // Bubble only kills valid and control; payload fields keep their old values.
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (bubble_cnt_q != CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
      end else begin
        valid_d    = idValid;
        ctrl_d     = id_ctrl;
        pc_d       = idPc;
        rs1_data_d = idRs1Data;
        rs2_data_d = idRs2Data;
        imm_d      = idImm;
        rs1_d      = idRs1;
        rs2_d      = idRs2;
        rd_d       = idRd;
        funct3_d   = idFunct3;
        funct7b5_d = idFunct7b5;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      funct7b5_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      funct7b5_q   <= funct7b5_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign exValid     = valid_q;
  assign exPc        = pc_q;
  assign exRs1Data   = rs1_data_q;
  assign exRs2Data   = rs2_data_q;
  assign exImm       = imm_q;
  assign exRs1       = rs1_q;
  assign exRs2       = rs2_q;
  assign exRd        = rd_q;
  assign exFunct3    = funct3_q;
  assign exFunct7b5  = funct7b5_q;
  assign exBranch    = ctrl_q.branch;
  assign exMemRead   = ctrl_q.mem_read;
  assign exMemToReg  = ctrl_q.mem_to_reg;
  assign exMemWrite  = ctrl_q.mem_write;
  assign exAluSrc    = ctrl_q.alu_src;
  assign exRegWrite  = ctrl_q.reg_write;
  assign exAluOp     = ctrl_q.alu_op;
  assign bubbleCount = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the opcode control decoder in the RV32I pipeline.
- Captures the decoder's control bits and the decode-stage operands/indices each cycle and presents them registered to the execute stage.
- Detects load-use hazards and converts them into a one-cycle bubble, producing the stall request that upstream stages use to freeze PC and IF/ID.
- Handles branch flush and external hold, and counts inserted load-use bubbles.

Parameters:
- XLEN, 32, datapath width of PC, register data and immediate.
- COUNT_WIDTH, 16, width of the saturating bubble counter.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  input  1  clock; all state updates on rising edge.
  - reset  input  1  synchronous active-high reset.
- Pipeline control inputs:
  - flush  input  1  branch-taken redirect; kill the instruction entering EX.
  - hold  input  1  external stall (memory wait); freeze all state.
- Decode-stage inputs:
  - idValid  input  1  decode slot holds a real instruction.
  - idPc  input  XLEN  PC of decode instruction.
  - idRs1, idRs2, idRd  input  5 each  register indices.
  - idUsesRs1, idUsesRs2  input  1 each  instruction reads that source.
  - idRs1Data, idRs2Data  input  XLEN each  register file read data.
  - idImm  input  XLEN  sign-extended immediate.
  - idFunct3  input  3  funct3 field.
  - idFunct7b5  input  1  instruction bit 30.
  - idBranch, idMemRead, idMemToReg, idMemWrite, idAluSrc, idRegWrite  input  1 each  decoder control bits.
  - idAluOp  input  2  decoder ALU op class.
- Execute-stage outputs:
  - exValid  output  1  EX slot holds a real instruction.
  - exPc, exRs1Data, exRs2Data, exImm  output  XLEN each  registered copies.
  - exRs1, exRs2, exRd  output  5 each  registered indices.
  - exFunct3  output  3  registered funct3.
  - exFunct7b5  output  1  registered bit 30.
  - exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite  output  1 each  registered control bits.
  - exAluOp  output  2  registered ALU op class.
- Status outputs:
  - loadUseStall  output  1  combinational stall request to IF/ID.
  - bubbleCount  output  COUNT_WIDTH  saturating count of load-use bubbles.

Behaviour:
- Reset, in the cycle after reset is sampled high:
  - Every ex* output is 0, including exValid, all control bits, exAluOp, data and indices.
  - bubbleCount is 0.
  - Reset overrides flush, hold and load-use.
- Hazard (combinational):
  - hazard = exValid & exMemRead & (exRd != 0) & idValid & ((idUsesRs1 & idRs1 == exRd) | (idUsesRs2 & idRs2 == exRd)).
  - loadUseStall = hazard & ~flush.
  - loadUseStall is independent of hold: it stays asserted during hold if the condition holds.
- Per-edge update, first matching rule wins:
  1. reset: clear as above.
  2. hold: all registers, including bubbleCount, retain their values.
  3. flush: bubble.
  4. hazard: bubble, and bubbleCount increments by 1, saturating at all-ones.
  5. otherwise: load; every ex* field takes its id* counterpart, and exValid takes idValid.
- Bubble definition:
  - exValid and all control bits (exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite, exAluOp) become 0.
  - exPc, data, immediate, indices and funct fields retain their previous values.
- Latency: exactly one cycle from id* to ex* on a load edge.
- A hazard lasts exactly one cycle when there is no hold: the bubble clears exMemRead, which deasserts hazard.
- No EX-stage side effects (memWrite, regWrite) may come from a bubble or flushed slot. This is guaranteed by the zeroed control bits.
- idValid = 0 on a load edge passes through as exValid = 0 with control bits copied as-is. Downstream must gate on exValid.
- flush and hazard together: flush wins; bubble inserted, bubbleCount unchanged, loadUseStall = 0.
- hold and flush together: hold wins; state frozen. Upstream holds flush until hold drops.
- bubbleCount wraps never; it stays at the maximum once reached.

Test Plan:
- Reset: drive reset 1 for 2 cycles with all id* nonzero -> every ex* = 0, bubbleCount = 0, loadUseStall = 0.
- Pass-through: idValid=1, idPc=0x100, idRd=5, idRegWrite=1, idAluOp=2'b10, idImm=0xFFFFFFF0 -> next cycle exValid=1, exPc=0x100, exRd=5, exRegWrite=1, exAluOp=2'b10, exImm=0xFFFFFFF0.
- Load-use:
  - Stimulus: load lw x7 (exMemRead=1, exRd=7), then decode add with idRs2=7, idUsesRs2=1.
  - Required: loadUseStall=1 for one cycle.
  - Required: next cycle exValid=0, exRegWrite=0, bubbleCount=1.
  - Required: following cycle loadUseStall=0 and the add loads.
- x0 and unused source:
  - exMemRead=1, exRd=0, idRs1=0 -> loadUseStall=0.
  - exRd=7, idRs1=7, idUsesRs1=0 -> loadUseStall=0.
- Flush priority:
  - Stimulus: hazard condition true and flush=1.
  - Required: loadUseStall=0; next cycle exValid=0, all control 0, bubbleCount unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles with changing id* -> ex* and bubbleCount frozen.
  - Preload bubbleCount to 0xFFFF with COUNT_WIDTH=16, then trigger a hazard -> bubbleCount stays 0xFFFF.
